// File: rtl/mux_n_to_1_scan_pkg.sv
// mux_n_to_1_scan_pkg: shared state encodings, mode constants and helpers for the scanning mux
package mux_n_to_1_scan_pkg;
    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
    localparam int   DWELL_50MHZ = 50_000_000;
    function automatic int cnt_w(input int dwell);
        return dwell > 1 ? $clog2(dwell) : 1;
    endfunction
endpackage

// File: rtl/mux_n_to_1_scan_if.sv
// mux_n_to_1_scan_if: data/select/control bundle of the scanning mux
//   din     : packed inputs, input i at din[i*WIDTH +: WIDTH]
//   sel_in  : manual select      mode : 0 manual, 1 auto-scan
//   hold    : freeze scan        dout : registered mux output
//   sel_out : active select      tick : one-cycle pulse per scan step
interface mux_n_to_1_scan_if #(
    parameter int WIDTH = 3,
    parameter int N_IN  = 4
);
    localparam int SEL_W = $clog2(N_IN);
    logic [N_IN*WIDTH-1:0] din;
    logic [SEL_W-1:0]      sel_in;
    logic                  mode;
    logic                  hold;
    logic [WIDTH-1:0]      dout;
    logic [SEL_W-1:0]      sel_out;
    logic                  tick;
    modport master (output din, sel_in, mode, hold, input dout, sel_out, tick);
    modport slave  (input din, sel_in, mode, hold, output dout, sel_out, tick);
endinterface

// File: rtl/mux_n_to_1_scan_dwell_counter.sv
// mux_n_to_1_scan_dwell_counter: free-running dwell timer that pulses tick on its last count
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force count to 0 (priority over en)
//   en         : advance count; wraps DWELL-1 -> 0
//   tick       : high while en and count == DWELL-1 (the wrapping cycle)
module mux_n_to_1_scan_dwell_counter
    import mux_n_to_1_scan_pkg::*;
#(
    parameter int DWELL = DWELL_50MHZ
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = cnt_w(DWELL);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = en && cnt_q == CW'(DWELL - 1);
        cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/mux_n_to_1_scan.sv
// mux_n_to_1_scan: registered N-to-1 mux with manual select or timed auto-scan with hold
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mux_n_to_1_scan_if (din, sel_in, mode, hold in; dout, sel_out, tick out)
module mux_n_to_1_scan
    import mux_n_to_1_scan_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int N_IN  = 4,
    parameter int DWELL = DWELL_50MHZ
) (
    input logic              clk,
    input logic              rst_n,
    mux_n_to_1_scan_if.slave bus
);
    localparam int SEL_W = $clog2(N_IN);
    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             tick_q;
    logic             clr, en, step;
    mux_n_to_1_scan_dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .tick  (step)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= ST_MANUAL;
        else        state_q <= state_d;
    always_comb
        state_d = bus.mode == MODE_MANUAL ? ST_MANUAL : bus.hold ? ST_HOLD : ST_SCAN;
    // Actions follow the decoded state of this cycle's inputs, so a mode drop or hold
    // on the wrapping cycle suppresses the step on that same edge.
    always_comb begin
        clr    = state_d == ST_MANUAL;
        en     = state_d == ST_SCAN;
        sel_d  = state_d == ST_MANUAL ? (int'(bus.sel_in) < N_IN ? bus.sel_in : sel_q)
               : !step                ? sel_q
               : sel_q == SEL_W'(N_IN - 1) ? '0 : sel_q + 1'b1;
        dout_d = bus.din[int'(sel_q)*WIDTH +: WIDTH];
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sel_q  <= '0;
            dout_q <= '0;
            tick_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            dout_q <= dout_d;
            tick_q <= step;
        end
    assign bus.dout    = dout_q;
    assign bus.sel_out = sel_q;
    assign bus.tick    = tick_q && state_q == ST_SCAN;
endmodule

// File: tb/tb_mux_n_to_1_scan.sv
// tb_mux_n_to_1_scan: directed checks of manual select, scan wrap, hold, collision and DWELL=1
module tb_mux_n_to_1_scan;
    import mux_n_to_1_scan_pkg::*;
    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;
    always #5 clk = ~clk;
    mux_n_to_1_scan_if #(.WIDTH(3), .N_IN(4)) ifa ();
    mux_n_to_1_scan_if #(.WIDTH(3), .N_IN(3)) ifb ();
    mux_n_to_1_scan_if #(.WIDTH(3), .N_IN(4)) ifc ();
    mux_n_to_1_scan #(.WIDTH(3), .N_IN(4), .DWELL(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    mux_n_to_1_scan #(.WIDTH(3), .N_IN(3), .DWELL(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    mux_n_to_1_scan #(.WIDTH(3), .N_IN(4), .DWELL(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    initial begin
        int sel_exp[13];
        int tick_exp[13];
        int dout_exp[13];
        int dc_exp[4];
        sel_exp  = '{2, 2, 3, 3, 3, 0, 0, 0, 1, 1, 1, 2, 2};
        tick_exp = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
        dout_exp = '{5, 5, 5, 7, 7, 7, 1, 1, 1, 2, 2, 2, 5};
        dc_exp   = '{1, 2, 5, 7};
        rst_n = 1'b0;
        ifa.din = {3'd7, 3'd5, 3'd2, 3'd1};
        ifb.din = {3'd5, 3'd2, 3'd1};
        ifc.din = {3'd7, 3'd5, 3'd2, 3'd1};
        ifa.sel_in = 2'd0; ifa.mode = MODE_MANUAL; ifa.hold = 1'b0;
        ifb.sel_in = 2'd0; ifb.mode = MODE_MANUAL; ifb.hold = 1'b0;
        ifc.sel_in = 2'd0; ifc.mode = MODE_MANUAL; ifc.hold = 1'b0;
        cyc(2);
        chk("rst_dout", 32'(ifa.dout), 0);
        chk("rst_sel", 32'(ifa.sel_out), 0);
        chk("rst_tick", 32'(ifa.tick), 0);
        rst_n = 1'b1;
        ifa.sel_in = 2'd2;
        cyc(1);
        chk("man_sel_e1", 32'(ifa.sel_out), 2);
        chk("man_dout_e1", 32'(ifa.dout), 1);
        cyc(1);
        chk("man_dout_e2", 32'(ifa.dout), 5);
        #1 rst_n = 1'b0;
        #1;
        chk("async_dout", 32'(ifa.dout), 0);
        chk("async_sel", 32'(ifa.sel_out), 0);
        chk("async_tick", 32'(ifa.tick), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        chk("rel_sel", 32'(ifa.sel_out), 2);
        chk("rel_dout", 32'(ifa.dout), 5);
        ifa.mode = MODE_SCAN;
        for (int i = 0; i < 13; i++) begin
            cyc(1);
            chk($sformatf("scan_sel[%0d]", i), 32'(ifa.sel_out), sel_exp[i]);
            chk($sformatf("scan_tick[%0d]", i), 32'(ifa.tick), tick_exp[i]);
            chk($sformatf("scan_dout[%0d]", i), 32'(ifa.dout), dout_exp[i]);
        end
        ifa.hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk($sformatf("hold_sel[%0d]", i), 32'(ifa.sel_out), 2);
            chk($sformatf("hold_tick[%0d]", i), 32'(ifa.tick), 0);
        end
        chk("hold_dout", 32'(ifa.dout), 5);
        ifa.hold = 1'b0;
        cyc(1);
        chk("resume_tick1", 32'(ifa.tick), 0);
        chk("resume_sel1", 32'(ifa.sel_out), 2);
        cyc(1);
        chk("resume_tick2", 32'(ifa.tick), 1);
        chk("resume_sel2", 32'(ifa.sel_out), 3);
        cyc(2);
        chk("pre_coll_tick", 32'(ifa.tick), 0);
        chk("pre_coll_sel", 32'(ifa.sel_out), 3);
        ifa.mode = MODE_MANUAL;
        ifa.sel_in = 2'd1;
        cyc(1);
        chk("coll_tick", 32'(ifa.tick), 0);
        chk("coll_sel", 32'(ifa.sel_out), 1);
        chk("coll_dout", 32'(ifa.dout), 7);
        cyc(1);
        chk("coll_dout2", 32'(ifa.dout), 2);
        ifb.sel_in = 2'd1;
        cyc(2);
        chk("n3_sel", 32'(ifb.sel_out), 1);
        chk("n3_dout", 32'(ifb.dout), 2);
        ifb.sel_in = 2'd3;
        cyc(2);
        chk("n3_oor_sel", 32'(ifb.sel_out), 1);
        chk("n3_oor_dout", 32'(ifb.dout), 2);
        ifb.mode = MODE_SCAN;
        cyc(3);
        chk("n3_scan_sel1", 32'(ifb.sel_out), 2);
        chk("n3_scan_tick1", 32'(ifb.tick), 1);
        cyc(3);
        chk("n3_wrap_sel", 32'(ifb.sel_out), 0);
        chk("n3_wrap_tick", 32'(ifb.tick), 1);
        ifc.mode = MODE_SCAN;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk($sformatf("d1_sel[%0d]", i), 32'(ifc.sel_out), (i + 1) % 4);
            chk($sformatf("d1_tick[%0d]", i), 32'(ifc.tick), 1);
            chk($sformatf("d1_dout[%0d]", i), 32'(ifc.dout), dc_exp[i]);
        end
        ifc.hold = 1'b1;
        ifc.mode = MODE_MANUAL;
        ifc.sel_in = 2'd2;
        cyc(1);
        chk("d1_man_sel", 32'(ifc.sel_out), 2);
        chk("d1_man_tick", 32'(ifc.tick), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mux_n_to_1_scan.md
Name: mux_n_to_1_scan

Overview:
- Parametrised, registered N-to-1 multiplexer. Generalises the 3-bit 2:1 board muxes to WIDTH bits and N_IN inputs.
- Adds an auto-scan mode: the select steps through all inputs on a programmable dwell timer, with a hold (freeze) control.
- Sits between board switch/data sources and LED/7-seg display logic in the intro_to_digital labs.

Parameters:
- WIDTH, 3: bits per data input and output.
- N_IN, 4: number of data inputs; must be ≥ 2.
- DWELL, 50000000: clock cycles per scan step (1 s at 50 MHz); must be ≥ 1.
- SEL_W, $clog2(N_IN) (localparam, derived): select width.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- din, input, N_IN*WIDTH: packed data inputs; input i occupies din[i*WIDTH +: WIDTH].
- sel_in, input, SEL_W: manual select.
- mode, input, 1: 0 = manual, 1 = auto-scan.
- hold, input, 1: in scan mode, freezes the dwell counter and select.
- dout, output, WIDTH: registered mux output.
- sel_out, output, SEL_W: current active select (registered).
- tick, output, 1: one-cycle pulse on the cycle sel_out advances in scan mode.

Behaviour:
- Reset (rst_n low, asynchronous):
  - dout = 0, sel_out = 0, tick = 0.
  - Dwell counter = 0, state = MANUAL.
  - Deassertion is taken at the next clk edge. Reset mid-scan abandons the count; there is no carry-over.
- States:
  - MANUAL: mode = 0.
  - SCAN: mode = 1, hold = 0.
  - HOLD: mode = 1, hold = 1.
  - Next state is decoded from mode and hold every cycle. mode = 0 overrides hold.
- Datapath latency:
  - dout(t+1) = din(t)[sel_out(t)], so there is one register stage after the select.
  - A new select reaches dout two edges after sel_in or a scan step changes.
- MANUAL:
  - sel_out(t+1) = sel_in(t) if sel_in < N_IN; otherwise sel_out holds its value (out-of-range is ignored).
  - Counter held at 0; tick = 0.
- SCAN:
  - Counter increments each cycle.
  - When counter == DWELL-1: counter -> 0, sel_out -> sel_out+1, wrapping N_IN-1 -> 0, and tick = 1 for that cycle.
  - sel_in is ignored.
- HOLD:
  - Counter and sel_out frozen; tick = 0; dout keeps tracking din[sel_out].
  - Releasing hold resumes counting from the frozen value.
- Entry and exit:
  - MANUAL -> SCAN: counter restarts at 0; scanning starts from the current sel_out.
  - SCAN/HOLD -> MANUAL: sel_out loads sel_in on the same edge.
- Simultaneous events:
  - mode falls on the cycle the counter reaches DWELL-1: no step, tick = 0, MANUAL wins.
  - hold rises on that cycle: no step, tick = 0.
- Boundary cases:
  - DWELL = 1: step every cycle while in SCAN; tick stays high continuously.
  - N_IN not a power of 2: wrap at N_IN-1, never at 2^SEL_W-1.
- Counter width is $clog2(DWELL) (minimum 1) and it never exceeds DWELL-1.

Decomposition:
- Shared header mux_defs.vh:
  - State encodings ST_MANUAL = 2'd0, ST_SCAN = 2'd1, ST_HOLD = 2'd2.
  - MODE_MANUAL / MODE_SCAN constants.
  - Default DWELL for a 50 MHz board clock.
- Sub-module dwell_counter:
  - Parameter DWELL; inputs clk, rst_n, clr, en; output tick.
  - Reused later by other scanning display blocks.
- Top-level board wrapper:
  - Separate from this block; maps SW/LEDR with N_IN = 2, WIDTH = 3 for backward-compatible lab use.

Test Plan (WIDTH=3, N_IN=4, DWELL=3; inputs 0..3 = 3'd1, 3'd2, 3'd5, 3'd7):
1. Reset: rst_n low mid-cycle -> dout, sel_out, tick all 0 immediately, without waiting for clk. After release with mode=0, sel_in=2 -> sel_out=2 after 1 edge, dout=5 after 2 edges.
2. Manual out-of-range: N_IN=3 build, sel_in=3 while sel_out=1 -> sel_out stays 1, dout stays din[1].
3. Scan wrap: mode=1 from sel_out=2 -> tick every 3rd cycle. sel_out sequence 2,3,0,1,2 and dout sequence 5,7,1,2,5, each lagging its select by one cycle.
4. Hold: raise hold after 1 scan cycle, keep it 10 cycles -> sel_out and tick frozen. After release, the next tick comes 2 cycles later, because the counter resumes and is not reset.
5. Collision: mode drops on the cycle counter == 2 -> tick = 0, no step, sel_out = sel_in on that edge.
6. DWELL=1 build in SCAN -> tick continuously high; sel_out advances every cycle 0,1,2,3,0.
